qam_demod_packer: RTL and testbench
===================================

# qam_demod_packer

Parametrised successor to the fixed 2-bit QPSK demodulator. It integrates SPS signed I/Q samples per symbol and hard-slices each symbol as QPSK or 16-QAM, selectable at run time, with Gray mapping. Decided bits are packed MSB-first into OUT_W-bit words. Words are delivered through a FIFO_DEPTH-entry output FIFO with a valid/ready handshake. The block sits between the matched-filter/sampler front end and the deframer.

## Interface
Parameters:
- SAMPLE_W, 8: signed two's-complement width of in_i and in_q.
- SPS, 4: samples integrated per symbol; must be ≥1.
- OUT_W, 8: packed output word width; must be a multiple of 4.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two and ≥2.
- QAM_THR, 64: per-sample 16-QAM inner/outer amplitude threshold.

Ports:
- CLOCK_256  in  1  single clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  the sample pair is valid this cycle; there is no input backpressure.
- in_i  in  SAMPLE_W  signed in-phase sample.
- in_q  in  SAMPLE_W  signed quadrature sample.
- sync  in  1  symbol-boundary restart; acts in the cycle it is asserted.
- mode  in  1  0 = QPSK (2 bits/symbol), 1 = 16-QAM (4 bits/symbol).
- out_data  out  OUT_W  word at the FIFO head.
- out_valid  out  1  FIFO is non-empty.
- out_ready  in  1  consumer accepts out_data.
- overflow  out  1  sticky flag: a completed word was dropped.
- symbol_count  out  32  symbols sliced; present only with DEMOD_STATS_EN.

## Operation
- Accumulator: acc_i and acc_q are SAMPLE_W+clog2(SPS)+1 bits, signed. A phase counter runs 0..SPS-1 and advances on each in_valid. On the sample at phase SPS-1 the final sums go to the slicer and the accumulator and phase return to 0.
- Slicer, per axis, with x = final sum:
  - sign bit s = (x < 0). Zero counts as positive.
  - inner bit m = (|x| < QAM_THR*SPS). The magnitude is computed at full width so -2^(W-1) cannot overflow.
- QPSK symbol: {s_I, s_Q}. Gray mapping: (+,+)=00, (+,-)=01, (-,-)=11, (-,+)=10.
- 16-QAM symbol: {s_I, m_I, s_Q, m_Q}. Per-axis levels are +3=00, +1=01, -1=11, -3=10.
- Mode latching: mode is latched when the packer is empty, i.e. when the first symbol of a word is sliced. Changes to mode mid-word are ignored until that word completes.
- Packer: shifts each symbol in MSB-first. When OUT_W bits have been collected, the word is pushed to the FIFO and the packer empties.
- FIFO push when full:
  - With no pop that cycle, the word is dropped and overflow is set. It stays set until reset.
  - With a simultaneous pop (out_valid & out_ready), the push is accepted.
- FIFO pop: occurs when out_valid & out_ready. out_data always shows the head entry and holds steady while out_ready is low.
- sync:
  - Clears the accumulator, the phase counter, the slicer stage register and the partial packer contents.
  - If in_valid is high in the same cycle, that sample becomes phase 0 of a new symbol.
  - FIFO contents and overflow are unaffected.
- Reset (asynchronous, legal mid-operation): clears everything at once, FIFO included.
- Reset values: out_valid=0, out_data=0, overflow=0, symbol_count=0.

## Timing
- Pipeline: accumulate edge, then slice-register edge, then pack edge, then FIFO write edge.
- Latency: the edge that accepts the final sample of a word-completing symbol is edge k. out_valid goes high after edge k+3 if the FIFO was empty.
- Throughput: one symbol per SPS valid samples. Back-to-back symbols need no idle cycles.
- Handshake: out_valid never drops without a pop or a reset. The FIFO head is stable while out_valid=1 and out_ready=0.
- sync in the same cycle that a symbol completes: that symbol is discarded.

## Configuration
- DEMOD_STATS_EN defined:
  - Adds the symbol_count port.
  - symbol_count increments once per sliced symbol, including symbols later discarded by sync or FIFO drop.
  - Wraps at 2^32 and is cleared by reset only.
- DEMOD_STATS_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
All scenarios use SAMPLE_W=8, SPS=4, OUT_W=8, FIFO_DEPTH=4, QAM_THR=64, and 4 samples per symbol.
- Reset: assert reset mid-stream -> out_valid=0, out_data=0, overflow=0 and symbol_count=0 immediately, with no clock edge needed.
- QPSK word: mode=0, symbols (+50,+50), (+50,-50), (-50,-50), (-50,+50) -> out_data=8'h1E. out_valid rises 3 edges after the last sample. symbol_count=4.
- 16-QAM word: mode=1, symbols (+100,-30) then (-100,+30) -> nibbles 0011, 1001 -> out_data=8'h39. Flipping mode after the first symbol does not change the result.
- Backpressure/overflow: out_ready=0, send 5 QPSK words (0x1E, 0x00, 0xFF, 0xAA, 0x55) -> overflow=1, 0x55 dropped. Raising out_ready then drains 0x1E, 0x00, 0xFF, 0xAA in order, one per cycle, and out_valid falls afterward.
- sync mid-word: 2 QPSK symbols (-,-), then sync, then 4 symbols (+,+), (+,+), (+,+), (+,-) -> a single word 8'h01; the partial bits never appear.
- Full and pop together: with the FIFO full, a word completes while out_ready=1 -> the push is accepted, overflow stays 0 and the occupancy stays at 4.

Source files
------------

// File: rtl/qam_demod_packer.sv
// qam_demod_packer: integrate-and-dump QPSK / 16-QAM hard-decision demodulator.
// Integrates SPS signed I/Q samples per symbol and slices each symbol with Gray
// mapping. Decided bits are packed MSB-first into OUT_W-bit words, and the words
// are buffered in a FIFO_DEPTH-entry output FIFO with a valid/ready handshake.
// Pipeline: accumulate -> slice register -> pack -> FIFO write.
// Optional feature macro: DEMOD_STATS_EN adds the 32-bit symbol_count output.
module qam_demod_packer #(
  parameter int SAMPLE_W   = 8,
  parameter int SPS        = 4,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int QAM_THR    = 64
) (
  input  logic                       CLOCK_256,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_i,
  input  logic signed [SAMPLE_W-1:0] in_q,
  input  logic                       sync,
  input  logic                       mode,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow
`ifdef DEMOD_STATS_EN
  ,
  output logic [31:0]                symbol_count
`endif
);

  // One guard bit on top of the clog2(SPS) growth keeps the sum exact.
  localparam int ACC_W  = SAMPLE_W + $clog2(SPS) + 1;
  localparam int PH_W   = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FILL_W = $clog2(OUT_W + 1);

  localparam logic [63:0]       THR_TOT   = 64'(QAM_THR) * 64'(SPS);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SPS - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(OUT_W);
  localparam logic [AW:0]       FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    MODE_QPSK  = 1'b0,
    MODE_QAM16 = 1'b1
  } mode_t;

  // Per-axis decision {sign, inner}. The magnitude is formed one bit wider than
  // the sum so the most negative sum negates without wrapping.
  function automatic logic [1:0] slice_axis(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W:0] xw;
    logic        [ACC_W:0] mag;
    xw  = {x[ACC_W-1], x};
    mag = (xw < 0) ? $unsigned(-xw) : $unsigned(xw);
    return {x[ACC_W-1], (64'(mag) < THR_TOT)};
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: integrate-and-dump accumulator
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic        [PH_W-1:0]  phase;
  logic signed [ACC_W-1:0] fin_i, fin_q;
  logic                    fin_valid;

  logic        [PH_W-1:0]  phase_eff;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic                    last_sample;

  // sync restarts the symbol in the same cycle, so the incoming sample (if any)
  // is summed onto a cleared accumulator at phase 0.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    phase_eff   = sync ? '0 : phase;
    sum_i       = (sync ? '0 : acc_i) + {{(ACC_W - SAMPLE_W){in_i[SAMPLE_W-1]}}, in_i};
    sum_q       = (sync ? '0 : acc_q) + {{(ACC_W - SAMPLE_W){in_q[SAMPLE_W-1]}}, in_q};
    last_sample = in_valid && (phase_eff == PH_LAST);
  end

  // Accumulate samples; dump the final sums to the slicer on the last phase.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_256 or posedge reset) begin
    if (reset) begin
      acc_i     <= '0;
      acc_q     <= '0;
      phase     <= '0;
      fin_i     <= '0;
      fin_q     <= '0;
      fin_valid <= 1'b0;
    end else begin
      fin_valid <= last_sample;
      if (last_sample) begin
        fin_i <= sum_i;
        fin_q <= sum_q;
        acc_i <= '0;
        acc_q <= '0;
        phase <= '0;
      end else if (in_valid) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        phase <= phase_eff + PH_W'(1);
      end else if (sync) begin
        acc_i <= '0;
        acc_q <= '0;
        phase <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: slice register with per-word mode latching
  // ---------------------------------------------------------------------------
  logic [3:0]        sym_bits;
  logic              sym_valid;
  logic              sym_last;
  mode_t             sym_mode;
  mode_t             word_mode;
  logic [FILL_W-1:0] slice_fill;

  logic [3:0]        slice_bits;
  mode_t             cur_mode;
  logic [FILL_W-1:0] fill_next;
  logic              word_done;

  // The word's mode is taken from the mode input when its first symbol is
  // sliced (fill == 0) and held until the word's last symbol is sliced.
  always_comb begin
    slice_bits = {slice_axis(fin_i), slice_axis(fin_q)};
    cur_mode   = (slice_fill == '0) ? mode_t'(mode) : word_mode;
    fill_next  = slice_fill + ((cur_mode == MODE_QAM16) ? FILL_W'(4) : FILL_W'(2));
    word_done  = (fill_next == FILL_FULL);
  end

  // Register the sliced symbol together with its mode and end-of-word flag.
  always_ff @(posedge CLOCK_256 or posedge reset) begin
    if (reset) begin
      sym_bits   <= '0;
      sym_valid  <= 1'b0;
      sym_last   <= 1'b0;
      sym_mode   <= MODE_QPSK;
      word_mode  <= MODE_QPSK;
      slice_fill <= '0;
    end else if (sync) begin
      sym_valid  <= 1'b0;
      slice_fill <= '0;
    end else begin
      sym_valid <= fin_valid;
      if (fin_valid) begin
        sym_bits   <= slice_bits;
        sym_last   <= word_done;
        sym_mode   <= cur_mode;
        word_mode  <= cur_mode;
        slice_fill <= word_done ? '0 : fill_next;
      end
    end
  end

`ifdef DEMOD_STATS_EN
  // Count every slicing event, even if sync or a full FIFO later discards it.
  always_ff @(posedge CLOCK_256 or posedge reset) begin
    if (reset) begin
      symbol_count <= '0;
    end else if (fin_valid) begin
      symbol_count <= symbol_count + 32'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 3: MSB-first packer
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] pack_sr;
  logic [OUT_W-1:0] word_data;
  logic             word_valid;

  logic [OUT_W+1:0] shift2;
  logic [OUT_W+3:0] shift4;
  logic [OUT_W-1:0] pack_next;

  // QPSK contributes {s_I, s_Q}; 16-QAM contributes {s_I, m_I, s_Q, m_Q}.
  always_comb begin
    shift2    = {pack_sr, sym_bits[3], sym_bits[1]};
    shift4    = {pack_sr, sym_bits};
    pack_next = (sym_mode == MODE_QAM16) ? shift4[OUT_W-1:0] : shift2[OUT_W-1:0];
  end

  // Shift symbols in; hand a completed word to the FIFO write stage.
  always_ff @(posedge CLOCK_256 or posedge reset) begin
    if (reset) begin
      pack_sr    <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= sym_valid && sym_last && !sync;
      if (sync) begin
        pack_sr <= '0;
      end else if (sym_valid) begin
        if (sym_last) begin
          word_data <= pack_next;
          pack_sr   <= '0;
        end else begin
          pack_sr <= pack_next;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: output FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  logic pop, full, push_ok, drop;

  // A push into a full FIFO still fits when the head leaves in the same cycle.
  always_comb begin
    pop     = out_valid && out_ready;
    full    = (count == FIFO_FULL);
    push_ok = word_valid && (!full || pop);
    drop    = word_valid && full && !pop;
  end

  // FIFO storage, pointers, occupancy and the sticky overflow flag.
  // NOTE: the storage array is reset as well, because out_data must read as
  // zero straight out of reset and a reset must flush stale words.
  always_ff @(posedge CLOCK_256 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= word_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_qam_demod_packer.sv
// Self-checking bench for qam_demod_packer (SAMPLE_W=8, SPS=4, OUT_W=8,
// FIFO_DEPTH=4, QAM_THR=64). Expected words are queued as stimulus is driven
// and compared by a monitor whenever the DUT hands a word over.
module tb_qam_demod_packer;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [7:0] in_i, in_q;
  logic              sync;
  logic              mode;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
`ifdef DEMOD_STATS_EN
  logic [31:0]       symbol_count;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  qam_demod_packer #(
    .SAMPLE_W  (8),
    .SPS       (4),
    .OUT_W     (8),
    .FIFO_DEPTH(4),
    .QAM_THR   (64)
  ) dut (
    .CLOCK_256   (clk),
    .reset       (rst),
    .in_valid    (in_valid),
    .in_i        (in_i),
    .in_q        (in_q),
    .sync        (sync),
    .mode        (mode),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow)
`ifdef DEMOD_STATS_EN
    ,
    .symbol_count(symbol_count)
`endif
  );

  // Scoreboard: compare every word the consumer accepts against the queue.
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %h, no word expected", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          bad++;
          $display("FAIL pop_data: got %h, required %h", out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_sym(input int i, input int q, input bit sync_first = 1'b0,
                          input int flip_at = -1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_i     = 8'(i);
      in_q     = 8'(q);
      sync     = sync_first && (j == 0);
      if (j == flip_at) mode = ~mode;
    end
  endtask

  task automatic send_qpsk_word(input logic [7:0] w, input bit expect_it);
    if (expect_it) exp_q.push_back(w);
    for (int s = 3; s >= 0; s--) begin
      send_sym(w[2*s+1] ? -50 : 50, w[2*s] ? -50 : 50);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      sync     = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    sync      = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: %0d words pending, out_valid=%b, required 0 and 0",
               name, exp_q.size(), out_valid);
    end
  endtask

`ifdef DEMOD_STATS_EN
  task automatic check_stats(input string name, input int unsigned exp);
    total++;
    if (symbol_count !== exp) begin
      bad++;
      $display("FAIL %s_symbol_count: got %0d, required %0d", name, symbol_count, exp);
    end
  endtask
`endif

  task automatic test_reset();
    do_reset();
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h, required 00", out_data); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
`ifdef DEMOD_STATS_EN
    check_stats("reset", 0);
`endif
    // Park one word in the FIFO and leave a partial word in the packer.
    out_ready = 1'b0;
    send_qpsk_word(8'h1E, 1'b1);
    send_sym(-50, -50);
    send_sym(-50, -50);
    idle(3);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h1E) begin
      bad++;
      $display("FAIL pre_reset_head: valid=%b data=%h, required 1 1e", out_valid, out_data);
    end
    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_out_valid: got %b, required 0", out_valid); end
    if (out_data !== 8'h00) begin bad++; $display("FAIL async_reset_out_data: got %h, required 00", out_data); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL async_reset_overflow: got %b, required 0", overflow); end
`ifdef DEMOD_STATS_EN
    check_stats("async_reset", 0);
`endif
    exp_q.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(10);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_partial_flushed: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_qpsk();
    do_reset();
    send_qpsk_word(8'h1E, 1'b1);
    // Last sample accepted at edge k; out_valid must rise only after edge k+3.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== (c == 3)) begin
        bad++;
        $display("FAIL qpsk_latency_k+%0d: out_valid=%b, required %b", c, out_valid, (c == 3));
      end
    end
    wait_drain("qpsk", 20);
`ifdef DEMOD_STATS_EN
    check_stats("qpsk", 4);
`endif
  endtask

  task automatic test_qam16();
    do_reset();
    mode = 1'b1;
    exp_q.push_back(8'h39);
    send_sym(100, -30);
    send_sym(-100, 30, 1'b0, 2);   // mode flips mid-word and must be ignored
    mode = 1'b1;
    exp_q.push_back(8'hC6);
    send_sym(-30, 100);
    send_sym(30, -100);
    // Zero is positive; a magnitude equal to the threshold is outer.
    exp_q.push_back(8'h4A);
    send_sym(0, 64);
    send_sym(-64, -128);
    idle(1);
    wait_drain("qam16", 20);
`ifdef DEMOD_STATS_EN
    check_stats("qam16", 6);
`endif
  endtask

  task automatic test_sync();
    do_reset();
    exp_q.push_back(8'h01);
    send_sym(-50, -50);
    send_sym(-50, -50);
    send_sym(50, 50, 1'b1);        // sync arrives with phase 0 of the new word
    send_sym(50, 50);
    send_sym(50, 50);
    send_sym(50, -50);
    idle(1);
    wait_drain("sync", 20);
    idle(8);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sync_extra_word: out_valid=%b, required 0", out_valid);
    end
`ifdef DEMOD_STATS_EN
    check_stats("sync", 6);
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    send_qpsk_word(8'h1E, 1'b1);
    send_qpsk_word(8'h00, 1'b1);
    send_qpsk_word(8'hFF, 1'b1);
    send_qpsk_word(8'hAA, 1'b1);
    send_qpsk_word(8'h55, 1'b0);
    idle(6);
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    if (out_valid !== 1'b1 || out_data !== 8'h1E) begin
      bad++;
      $display("FAIL ovf_head_hold: valid=%b data=%h, required 1 1e", out_valid, out_data);
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL ovf_drain_cycle%0d: out_valid=%b, required 1", c, out_valid);
      end
      @(negedge clk);
    end
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: out_valid=%b, required 0", out_valid); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_pending: %0d words pending, required 0", exp_q.size()); end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_reset_clear: got %b, required 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    out_ready = 1'b0;
    send_qpsk_word(8'h1E, 1'b1);
    send_qpsk_word(8'h33, 1'b1);
    send_qpsk_word(8'hC3, 1'b1);
    send_qpsk_word(8'h99, 1'b1);
    idle(4);
    send_qpsk_word(8'h5A, 1'b1);
    @(negedge clk);                // after edge k
    in_valid = 1'b0;
    @(negedge clk);                // after edge k+1
    @(negedge clk);                // after edge k+2
    out_ready = 1'b1;              // pop coincides with the push at edge k+3
    @(negedge clk);
    out_ready = 1'b0;
    idle(3);
    total += 2;
    if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_overflow: got %b, required 0", overflow); end
    if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      bad++;
      $display("FAIL fullpop_head: valid=%b data=%h, required 1 33", out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL fullpop_occupancy%0d: out_valid=%b, required 1", c, out_valid);
      end
      @(negedge clk);
    end
    wait_drain("fullpop", 2);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_i      = '0;
    in_q      = '0;
    sync      = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;
    #12;
    test_reset();
    test_qpsk();
    test_qam16();
    test_sync();
    test_overflow();
    test_full_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
